// File: rtl/fifo_ctrl_pkg.sv
// Shared defaults and slot encodings for the FIFO access controller.
package fifo_ctrl_pkg;
  localparam int DEPTH_DEF   = 8;
  localparam int WIDTH_DEF   = 8;
  localparam int RD_PRIO_DEF = 6;
  localparam int CNT_W       = $clog2(DEPTH_DEF + 1);

  localparam logic [1:0] SLOT_A = 2'd0;
  localparam logic [1:0] SLOT_B = 2'd1;
  localparam logic [1:0] SLOT_R = 2'd2;
endpackage

// File: rtl/fifo_access_ctrl_chk.sv
// Safety checker for the FIFO access controller: one command per cycle, count stays in range.
module fifo_access_ctrl_chk #(
  parameter int DEPTH = 8,
  parameter int OCC_W = $clog2(DEPTH + 1)
)(
  input logic             clk,
  input logic             reset,
  input logic             a_ready,
  input logic             b_ready,
  input logic             rd_ack,
  input logic             fifo_wr_en,
  input logic             fifo_rd_en,
  input logic [OCC_W-1:0] occupancy
);

  // Checks only outside reset, when the controller state is defined.
  always @(posedge clk) begin
    if (!reset) begin
      assert (!(fifo_wr_en && fifo_rd_en)) else $error("chk: write and read strobes together");
      assert ($countones({a_ready, b_ready, rd_ack}) <= 32'd1) else $error("chk: grant not one-hot");
      assert (!((a_ready || b_ready) && occupancy == OCC_W'(DEPTH))) else $error("chk: count overflow");
      assert (!(rd_ack && occupancy == {OCC_W{1'b0}})) else $error("chk: count underflow");
      assert (occupancy <= OCC_W'(DEPTH)) else $error("chk: count out of range");
    end
  end

endmodule

// File: rtl/rr_arb3.sv
// Three-way round-robin arbiter (A, B, R) with a read-priority override.
module rr_arb3
  import fifo_ctrl_pkg::*;
(
  input  logic [2:0] req,
  input  logic [1:0] ptr,
  input  logic       prio_en,
  output logic [2:0] grant,
  output logic [1:0] next_ptr
);

  // Pick the first requester at or after the pointer, unless the read override applies.
  always_comb begin
    grant = 3'b000;
    if (prio_en && req[SLOT_R]) begin
      grant = 3'b100;
    end else begin
      case (ptr)
        SLOT_B: begin
          if (req[SLOT_B])      grant = 3'b010;
          else if (req[SLOT_R]) grant = 3'b100;
          else if (req[SLOT_A]) grant = 3'b001;
          else                  grant = 3'b000;
        end
        SLOT_R: begin
          if (req[SLOT_R])      grant = 3'b100;
          else if (req[SLOT_A]) grant = 3'b001;
          else if (req[SLOT_B]) grant = 3'b010;
          else                  grant = 3'b000;
        end
        default: begin
          if (req[SLOT_A])      grant = 3'b001;
          else if (req[SLOT_B]) grant = 3'b010;
          else if (req[SLOT_R]) grant = 3'b100;
          else                  grant = 3'b000;
        end
      endcase
    end
  end

  // Pointer moves to the slot after the winner; holds when nothing is granted.
  always_comb begin
    case (grant)
      3'b001:  next_ptr = SLOT_B;
      3'b010:  next_ptr = SLOT_R;
      3'b100:  next_ptr = SLOT_A;
      default: next_ptr = ptr;
    endcase
  end

endmodule

// File: rtl/fifo_access_ctrl.sv
// Shares one FIFO between producers A/B and a consumer; one registered command per cycle.
module fifo_access_ctrl
  import fifo_ctrl_pkg::*;
#(
  parameter int DEPTH       = DEPTH_DEF,
  parameter int WIDTH       = WIDTH_DEF,
  parameter int RD_PRIO_LVL = RD_PRIO_DEF,
  localparam int OCC_W      = $clog2(DEPTH + 1)
)(
  input  logic             clk,
  input  logic             reset,
  input  logic             a_valid,
  input  logic [WIDTH-1:0] a_data,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [WIDTH-1:0] b_data,
  output logic             b_ready,
  input  logic             rd_req,
  output logic             rd_ack,
  output logic             rd_valid,
  output logic [WIDTH-1:0] rd_data,
  output logic             fifo_wr_en,
  output logic             fifo_rd_en,
  output logic [WIDTH-1:0] fifo_din,
  input  logic [WIDTH-1:0] fifo_dout,
  output logic [OCC_W-1:0] occupancy
);

  logic [OCC_W-1:0] cnt_r;
  logic [1:0]       ptr_r;
  logic [1:0]       next_ptr_s;
  logic [2:0]       req_s;
  logic [2:0]       grant_s;
  logic             prio_s;
  logic             wr_grant_s;
  logic             wr_en_r;
  logic             rd_en_r;
  logic [WIDTH-1:0] din_r;
  logic [1:0]       rd_pipe_r;

  // Eligibility from the shadow count; nothing is granted while reset is held.
  always_comb begin
    req_s  = 3'b000;
    prio_s = (cnt_r >= OCC_W'(RD_PRIO_LVL));
    if (!reset) begin
      req_s[SLOT_A] = a_valid && (cnt_r < OCC_W'(DEPTH));
      req_s[SLOT_B] = b_valid && (cnt_r < OCC_W'(DEPTH));
      req_s[SLOT_R] = rd_req && (cnt_r != {OCC_W{1'b0}});
    end else begin
      req_s = 3'b000;
    end
  end

  rr_arb3 u_arb (
    .req      (req_s),
    .ptr      (ptr_r),
    .prio_en  (prio_s),
    .grant    (grant_s),
    .next_ptr (next_ptr_s)
  );

  assign a_ready    = grant_s[SLOT_A];
  assign b_ready    = grant_s[SLOT_B];
  assign rd_ack     = grant_s[SLOT_R];
  assign wr_grant_s = grant_s[SLOT_A] | grant_s[SLOT_B];

  // Command registers, read-valid pipeline, arbitration pointer and shadow count.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r     <= {OCC_W{1'b0}};
      ptr_r     <= SLOT_A;
      wr_en_r   <= 1'b0;
      rd_en_r   <= 1'b0;
      din_r     <= {WIDTH{1'b0}};
      rd_pipe_r <= 2'b00;
    end else begin
      ptr_r     <= next_ptr_s;
      wr_en_r   <= wr_grant_s;
      rd_en_r   <= grant_s[SLOT_R];
      din_r     <= grant_s[SLOT_A] ? a_data : (grant_s[SLOT_B] ? b_data : {WIDTH{1'b0}});
      rd_pipe_r <= {rd_pipe_r[0], grant_s[SLOT_R]};
      if (wr_grant_s) begin
        cnt_r <= cnt_r + OCC_W'(1);
      end else if (grant_s[SLOT_R]) begin
        cnt_r <= cnt_r - OCC_W'(1);
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

  assign fifo_wr_en = wr_en_r;
  assign fifo_rd_en = rd_en_r;
  assign fifo_din   = din_r;
  assign occupancy  = cnt_r;
  // FIFO output is registered on the read strobe, so it lines up with the second pipe stage.
  assign rd_valid   = rd_pipe_r[1];
  assign rd_data    = rd_pipe_r[1] ? fifo_dout : {WIDTH{1'b0}};

endmodule

// File: tb/tb_fifo_access_ctrl.sv
// Bench: controller plus a behavioural FIFO, checked against a queue-based reference model.
module tb_fifo_access_ctrl;
  localparam int DEPTH = 8;
  localparam int WIDTH = 8;
  localparam int PRIO  = 6;

  logic             clk = 1'b0;
  logic             reset;
  logic             a_valid, b_valid, rd_req;
  logic [WIDTH-1:0] a_data, b_data;
  logic             a_ready, b_ready, rd_ack, rd_valid;
  logic [WIDTH-1:0] rd_data, fifo_din, fifo_dout;
  logic             fifo_wr_en, fifo_rd_en;
  logic [3:0]       occupancy;

  always #5 clk = ~clk;

  fifo_access_ctrl #(.DEPTH(DEPTH), .WIDTH(WIDTH), .RD_PRIO_LVL(PRIO)) dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
    .rd_req(rd_req), .rd_ack(rd_ack), .rd_valid(rd_valid), .rd_data(rd_data),
    .fifo_wr_en(fifo_wr_en), .fifo_rd_en(fifo_rd_en), .fifo_din(fifo_din),
    .fifo_dout(fifo_dout), .occupancy(occupancy)
  );

  fifo_access_ctrl_chk #(.DEPTH(DEPTH)) u_chk (
    .clk(clk), .reset(reset), .a_ready(a_ready), .b_ready(b_ready), .rd_ack(rd_ack),
    .fifo_wr_en(fifo_wr_en), .fifo_rd_en(fifo_rd_en), .occupancy(occupancy)
  );

  // Behavioural FIFO, reset together with the controller.
  logic [WIDTH-1:0] mem [0:DEPTH-1];
  logic [2:0]       wp, rp;
  always @(posedge clk) begin
    if (reset) begin
      wp <= 3'd0;
      rp <= 3'd0;
    end else begin
      if (fifo_wr_en) begin
        mem[wp] <= fifo_din;
        wp      <= wp + 3'd1;
      end
      if (fifo_rd_en) begin
        fifo_dout <= mem[rp];
        rp        <= rp + 3'd1;
      end
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model state
  int             m_cnt, m_ptr, last_g;
  bit             m_wr, m_rd, m_p0, m_p1;
  logic [7:0]     m_din, m_d0, m_d1;
  logic [7:0]     m_q[$];
  logic           obs_a, obs_b, obs_r, obs_wr, obs_rd, obs_rv;
  logic [7:0]     obs_din, obs_rdata;
  int             obs_occ;

  task automatic model_reset();
    m_cnt = 0; m_ptr = 0; m_wr = 0; m_rd = 0; m_p0 = 0; m_p1 = 0;
    m_din = 8'h00; m_d0 = 8'h00; m_d1 = 8'h00;
    m_q.delete();
  endtask

  // One cycle: compare DUT against the model mid-cycle, then advance the model.
  task automatic tick();
    int g;
    bit el[3];
    @(negedge clk);
    el[0] = a_valid && (m_cnt < DEPTH) && !reset;
    el[1] = b_valid && (m_cnt < DEPTH) && !reset;
    el[2] = rd_req && (m_cnt > 0) && !reset;
    g = -1;
    if (el[2] && m_cnt >= PRIO) g = 2;
    else for (int k = 0; k < 3; k++) if (g < 0 && el[(m_ptr + k) % 3]) g = (m_ptr + k) % 3;

    check("a_ready", a_ready, g == 0);
    check("b_ready", b_ready, g == 1);
    check("rd_ack", rd_ack, g == 2);
    check("occupancy", occupancy, m_cnt);
    check("fifo_wr_en", fifo_wr_en, m_wr);
    check("fifo_rd_en", fifo_rd_en, m_rd);
    if (m_wr) check("fifo_din", fifo_din, m_din);
    check("rd_valid", rd_valid, m_p1);
    check("rd_data", rd_data, m_p1 ? m_d1 : 8'h00);

    obs_a = a_ready; obs_b = b_ready; obs_r = rd_ack; obs_wr = fifo_wr_en; obs_rd = fifo_rd_en;
    obs_rv = rd_valid; obs_din = fifo_din; obs_rdata = rd_data; obs_occ = int'(occupancy);
    last_g = g;

    if (reset) begin
      model_reset();
    end else begin
      m_p1 = m_p0; m_d1 = m_d0;
      m_wr = (g == 0) || (g == 1);
      m_rd = (g == 2);
      m_p0 = (g == 2);
      if (g == 0) m_din = a_data;
      if (g == 1) m_din = b_data;
      if (m_wr) begin m_q.push_back(m_din); m_cnt++; end
      if (m_rd) begin m_d0 = m_q.pop_front(); m_cnt--; end
      if (g >= 0) m_ptr = (g + 1) % 3;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    a_valid = 1'b0; b_valid = 1'b0; rd_req = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  logic [7:0] t3_vals [4];
  logic [7:0] got_vals [$];

  initial begin
    reset = 1'b1; a_valid = 1'b0; b_valid = 1'b0; rd_req = 1'b0;
    a_data = 8'h00; b_data = 8'h00;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    tick();
    reset = 1'b0;

    // Single transfer latency
    a_valid = 1'b1; a_data = 8'hEF;
    tick();
    check("t1_a_ready", obs_a, 1);
    a_valid = 1'b0;
    tick();
    check("t1_wr_en", obs_wr, 1);
    check("t1_din", obs_din, 8'hEF);
    check("t1_occ", obs_occ, 1);

    // Two producers alternate until full; reads still flow when full
    do_reset();
    a_valid = 1'b1; b_valid = 1'b1; a_data = 8'h11; b_data = 8'h22;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i < 8) check("t2_grant", {obs_b, obs_a}, (i % 2 == 0) ? 2'b01 : 2'b10);
      else check("t2_full_block", {obs_b, obs_a}, 2'b00);
      if (last_g == 0) a_data = 8'($urandom);
      if (last_g == 1) b_data = 8'($urandom);
    end
    check("t2_occ_full", obs_occ, 8);
    a_valid = 1'b0; b_valid = 1'b0; rd_req = 1'b1;
    tick();
    check("t2_read_when_full", obs_r, 1);
    rd_req = 1'b0;

    // Ordered drain
    do_reset();
    t3_vals[0] = 8'h5E; t3_vals[1] = 8'h20; t3_vals[2] = 8'h12; t3_vals[3] = 8'h34;
    a_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a_data = t3_vals[i];
      tick();
    end
    a_valid = 1'b0; rd_req = 1'b1;
    got_vals.delete();
    for (int i = 0; i < 8; i++) begin
      tick();
      if (obs_rv) got_vals.push_back(obs_rdata);
    end
    check("t3_count", got_vals.size(), 4);
    for (int i = 0; i < 4; i++) if (i < got_vals.size()) check("t3_data", got_vals[i], t3_vals[i]);
    check("t3_empty_no_ack", obs_r, 0);
    check("t3_occ_empty", obs_occ, 0);
    rd_req = 1'b0;

    // Read priority at high occupancy
    do_reset();
    a_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      a_data = 8'(8'h60 + i);
      tick();
    end
    b_valid = 1'b1; b_data = 8'hB0; rd_req = 1'b1;
    tick();
    check("t4_prio_read", obs_r, 1);
    tick();
    check("t4_occ5", obs_occ, 5);
    check("t4_rr_a", obs_a, 1);
    a_valid = 1'b0; b_valid = 1'b0; rd_req = 1'b0;

    // Reset right after a read grant
    do_reset();
    a_valid = 1'b1; a_data = 8'h77;
    tick();
    a_valid = 1'b0; rd_req = 1'b1;
    tick();
    check("t5_ack", obs_r, 1);
    rd_req = 1'b0; reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    check("t5_rv", obs_rv, 0);
    check("t5_wr", obs_wr, 0);
    check("t5_rd", obs_rd, 0);
    check("t5_occ", obs_occ, 0);
    tick();
    check("t5_rv2", obs_rv, 0);

    // Random traffic with producers holding data until granted
    for (int n = 0; n < 10000; n++) begin
      if (!(a_valid && last_g != 0)) begin
        a_valid = 1'($urandom_range(0, 1));
        a_data  = 8'($urandom);
      end
      if (!(b_valid && last_g != 1)) begin
        b_valid = 1'($urandom_range(0, 1));
        b_data  = 8'($urandom);
      end
      rd_req = 1'($urandom_range(0, 1));
      reset  = ($urandom_range(0, 511) == 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
